// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams the rate part of a Keccak state as byte-keyed beats.
// It requests a permutation when more output is needed than the current block holds.
module keccak_squeeze #(
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = DWIDTH / 8,
    parameter int LANE_SIZE  = 64,
    parameter int RATE_WIDTH = 11,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic [LEN_WIDTH-1:0]  out_len_i,
    input  logic [LANE_SIZE-1:0]  state_array_i [5][5],
    input  logic                  state_valid_i,
    output logic                  perm_req_o,
    output logic [DWIDTH-1:0]     m_data_o,
    output logic [KEEP_WIDTH-1:0] m_keep_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int MAX_LANES = 21;
    localparam int SNAP_W    = MAX_LANES * LANE_SIZE;
    localparam int RB_W      = RATE_WIDTH - 3;
    localparam int LN_W      = RATE_WIDTH - 6;

    typedef enum logic [1:0] {IDLE, STREAM, PERM_WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [RB_W-1:0]       rate_bytes_q, rate_bytes_d;
    logic [RB_W-1:0]       offset_q, offset_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic                  m_valid_q, m_valid_d;
    logic                  perm_req_q, perm_req_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [LN_W-1:0]       lanes;
    logic [SNAP_W-1:0]     snap_new;
    logic [LEN_WIDTH-1:0]  avail, n;
    logic [KEEP_WIDTH:0]   keep_full;
    logic [DWIDTH-1:0]     win;
    logic [RB_W-1:0]       off_nx;
    logic [LEN_WIDTH-1:0]  rem_nx;
    logic                  hs;

    // Only rate lanes are captured, so capacity lanes can never reach the output.
    always_comb begin
        lanes    = (state_q == IDLE) ? rate_i[RATE_WIDTH-1:6] : rate_bytes_q[RB_W-1:3];
        snap_new = '0;
        for (int l = 0; l < MAX_LANES; l++)
            if (l < int'(lanes)) snap_new[l*LANE_SIZE +: LANE_SIZE] = state_array_i[l%5][l/5];
    end

    always_comb begin
        avail     = LEN_WIDTH'(rate_bytes_q - offset_q);
        n         = LEN_WIDTH'(KEEP_WIDTH);
        n         = (avail < n) ? avail : n;
        n         = (remaining_q < n) ? remaining_q : n;
        keep_full = ((KEEP_WIDTH+1)'(1) << n) - (KEEP_WIDTH+1)'(1);
        win       = DWIDTH'(snap_q >> {offset_q, 3'b000});
        hs        = m_valid_q && m_ready_i;
        off_nx    = offset_q + RB_W'(n);
        rem_nx    = remaining_q - n;
        m_data_o  = '0;
        for (int k = 0; k < KEEP_WIDTH; k++)
            m_data_o[8*k +: 8] = (m_valid_q && keep_full[k]) ? win[8*k +: 8] : 8'h00;
        m_keep_o  = m_valid_q ? keep_full[KEEP_WIDTH-1:0] : '0;
        m_last_o  = m_valid_q && (remaining_q == n);
    end

    always_comb begin
        state_d      = state_q;
        rate_bytes_d = rate_bytes_q;
        offset_d     = offset_q;
        remaining_d  = remaining_q;
        snap_d       = snap_q;
        case (state_q)
            IDLE: if (start_i) begin
                rate_bytes_d = rate_i[RATE_WIDTH-1:3];
                remaining_d  = out_len_i;
                offset_d     = '0;
                snap_d       = snap_new;
                state_d      = (out_len_i == '0) ? DONE : STREAM;
            end
            STREAM: if (hs) begin
                offset_d    = off_nx;
                remaining_d = rem_nx;
                state_d     = (rem_nx == '0) ? DONE : (off_nx == rate_bytes_q) ? PERM_WAIT : STREAM;
            end
            PERM_WAIT: if (state_valid_i) begin
                snap_d   = snap_new;
                offset_d = '0;
                state_d  = STREAM;
            end
            default: state_d = IDLE;
        endcase
        m_valid_d  = state_d == STREAM;
        perm_req_d = (state_q == STREAM) && (state_d == PERM_WAIT);
        done_d     = state_d == DONE;
        busy_d     = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rate_bytes_q <= '0;
            offset_q     <= '0;
            remaining_q  <= '0;
            snap_q       <= '0;
            m_valid_q    <= 1'b0;
            perm_req_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_bytes_q <= rate_bytes_d;
            offset_q     <= offset_d;
            remaining_q  <= remaining_d;
            snap_q       <= snap_d;
            m_valid_q    <= m_valid_d;
            perm_req_q   <= perm_req_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign m_valid_o  = m_valid_q;
    assign perm_req_o = perm_req_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
endmodule
